wb_stage: RTL and testbench

- MEM/WB pipeline register plus the writeback datapath of the 5-stage RV32 core.
- Captures the instruction leaving MEM and extracts and sign/zero-extends load data from the synchronous data memory.
- Drives the register file write port (wb_en, wb_addr, write_data) and the EX-stage forwarding path.
- Guarantees exactly one register write per retired instruction across stalls.

---
 rtl/wb_stage_pkg.sv | 23 ++
 rtl/wb_stage_if.sv | 36 +++
 rtl/wb_stage_load_align.sv | 33 +++
 rtl/wb_stage.sv | 64 ++++++
 tb/tb_wb_stage.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared core definitions for the MEM/WB stage: load funct3 encodings and
// the pipeline register layout.
package wb_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 6;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            is_load;
        logic [2:0]      funct3;
        logic [XLEN-1:0] result;
    } mem_wb_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bundle: MEM-side instruction fields and data memory read word in,
// register file write port and forwarding path out.
interface wb_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 6
);
    logic            stall;
    logic            flush;
    logic            mem_valid;
    logic [RA_W-1:0] mem_rd;
    logic            mem_reg_write;
    logic            mem_is_load;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_result;
    logic [XLEN-1:0] dm_rdata;

    logic            wb_en;
    logic [RA_W-1:0] wb_addr;
    logic [XLEN-1:0] write_data;
    logic            fwd_valid;
    logic [RA_W-1:0] fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            retire;

    modport master (
        output stall, flush, mem_valid, mem_rd, mem_reg_write, mem_is_load,
               mem_funct3, mem_result, dm_rdata,
        input  wb_en, wb_addr, write_data, fwd_valid, fwd_rd, fwd_data, retire
    );

    modport slave (
        input  stall, flush, mem_valid, mem_rd, mem_reg_write, mem_is_load,
               mem_funct3, mem_result, dm_rdata,
        output wb_en, wb_addr, write_data, fwd_valid, fwd_rd, fwd_data, retire
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load data extraction: selects the byte/halfword lane addressed by off and
// sign- or zero-extends it according to funct3.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        case (off)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
            F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath: load extraction, register
// file write port and forwarding, with exactly one write per retired instruction.
module wb_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 6
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave bus
);
    import wb_stage_pkg::mem_wb_t;

    mem_wb_t         r;
    logic            committed;
    logic            hold_vld;
    logic [XLEN-1:0] hold_data;
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r         <= '0;
            committed <= 1'b0;
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (!bus.stall) begin
            r.valid     <= bus.mem_valid & ~bus.flush;
            r.rd        <= bus.mem_rd;
            r.reg_write <= bus.mem_reg_write;
            r.is_load   <= bus.mem_is_load;
            r.funct3    <= bus.mem_funct3;
            r.result    <= bus.mem_result;
            committed   <= 1'b0;
            hold_vld    <= 1'b0;
        end else begin
            // Write fired in the first WB cycle; memory word is gone after it.
            if (r.valid)
                committed <= 1'b1;
            if (r.valid && r.is_load && !hold_vld) begin
                hold_vld  <= 1'b1;
                hold_data <= bus.dm_rdata;
            end
        end
    end

    assign word = hold_vld ? hold_data : bus.dm_rdata;

    load_align u_load_align (
        .word   (word),
        .off    (r.result[1:0]),
        .funct3 (r.funct3),
        .data   (ld_data)
    );

    assign wdata          = r.is_load ? ld_data : r.result;
    assign bus.write_data = wdata;
    assign bus.fwd_data   = wdata;
    assign bus.wb_addr    = r.rd;
    assign bus.fwd_rd     = r.rd;
    assign bus.wb_en      = r.valid & r.reg_write & ~committed;
    assign bus.fwd_valid  = r.valid & r.reg_write;
    assign bus.retire     = r.valid & ~committed;
endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a per-instruction
// reference model (age in WB, word seen in its first WB cycle).
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(32), .RA_W(6)) bus ();

    wb_stage #(.XLEN(32), .RA_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference model of the instruction sitting in WB.
    bit          m_valid, m_rw, m_ld;
    logic [5:0]  m_rd;
    logic [2:0]  m_f3;
    logic [31:0] m_res, m_word;
    int unsigned m_age;

    logic        obs_wb_en, obs_retire, obs_fwd_valid;
    logic [5:0]  obs_addr;
    logic [31:0] obs_fwd_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_ld = 0;
        m_rd = '0; m_f3 = '0; m_res = '0; m_word = '0; m_age = 0;
    endtask

    task automatic check_model();
        bit          live;
        logic [31:0] w, exp_wd;
        live = m_valid && (m_age == 0);
        check_val("wb_en",     32'(bus.wb_en),     32'(live && m_rw));
        check_val("retire",    32'(bus.retire),    32'(live));
        check_val("fwd_valid", 32'(bus.fwd_valid), 32'(m_valid && m_rw));
        check_val("wb_addr",   32'(bus.wb_addr),   32'(m_rd));
        check_val("fwd_rd",    32'(bus.fwd_rd),    32'(m_rd));
        if (m_valid || !m_ld) begin
            w      = (m_age == 0) ? bus.dm_rdata : m_word;
            exp_wd = m_ld ? ref_load(w, m_res[1:0], m_f3) : m_res;
            check_val("write_data", bus.write_data, exp_wd);
            check_val("fwd_data",   bus.fwd_data,   exp_wd);
        end
        obs_wb_en     = bus.wb_en;
        obs_retire    = bus.retire;
        obs_fwd_valid = bus.fwd_valid;
        obs_addr      = bus.wb_addr;
        obs_fwd_data  = bus.fwd_data;
    endtask

    // Starts and ends at a negedge; checks 1ns after driving, updates model at posedge.
    task automatic do_cycle(input bit v, input logic [5:0] rd, input bit rw, input bit ld,
                            input logic [2:0] f3, input logic [31:0] res,
                            input bit stl, input bit fl, input logic [31:0] dm);
        bus.mem_valid = v; bus.mem_rd = rd; bus.mem_reg_write = rw; bus.mem_is_load = ld;
        bus.mem_funct3 = f3; bus.mem_result = res; bus.stall = stl; bus.flush = fl;
        bus.dm_rdata = dm;
        #1;
        check_model();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (!stl) begin
            m_valid = v && !fl; m_rd = rd; m_rw = rw; m_ld = ld; m_f3 = f3; m_res = res;
            m_age = 0;
        end else begin
            if (m_age == 0) m_word = dm;
            if (m_age < 3) m_age++;
        end
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        do_cycle($urandom_range(0, 9) < 8, 6'($urandom_range(0, 63)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom);
    endtask

    logic [1:0]  ld_off [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        int unsigned cnt_en, cnt_ret;
        rst = 1'b0;
        bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_reg_write = 0; bus.mem_is_load = 0;
        bus.mem_funct3 = '0; bus.mem_result = '0; bus.stall = 0; bus.flush = 0;
        bus.dm_rdata = '0;
        model_reset();
        @(negedge clk);

        repeat (4) rand_cycle();
        rst = 1'b1;
        repeat (2) do_cycle(0, 6'd0, 0, 0, 3'd0, 32'h0, 0, 0, 32'h0);

        // ALU write to x5
        do_cycle(1, 6'd5, 1, 0, 3'd0, 32'h1234_5678, 0, 0, 32'h0);
        bus.mem_valid = 0; #1;
        check_val("alu_wb_en",  32'(bus.wb_en),   32'd1);
        check_val("alu_addr",   32'(bus.wb_addr), 32'd5);
        check_val("alu_data",   bus.write_data,   32'h1234_5678);
        check_val("alu_retire", 32'(bus.retire),  32'd1);

        for (int i = 0; i < 5; i++) begin
            do_cycle(1, 6'd10, 1, 1, ld_f3[i], 32'h0000_1000 | 32'(ld_off[i]), 0, 0, $urandom);
            bus.mem_valid = 0; bus.dm_rdata = 32'h80FF_7F01; #1;
            check_val($sformatf("load_%0d", i), bus.write_data, ld_exp[i]);
        end

        // Load to x7 held across a 3-cycle stall while memory data changes
        do_cycle(1, 6'd7, 1, 1, 3'b010, 32'h200, 0, 0, 32'h0);
        cnt_en = 0; cnt_ret = 0;
        for (int c = 0; c < 4; c++) begin
            do_cycle(0, 6'd0, 0, 0, 3'd0, 32'h0, c < 3, 0, (c == 0) ? 32'hDEAD_BEEF : 32'h0);
            cnt_en += 32'(obs_wb_en);
            cnt_ret += 32'(obs_retire);
            check_val($sformatf("stall_fwd_%0d", c), obs_fwd_data, 32'hDEAD_BEEF);
        end
        check_val("stall_wb_en_count", cnt_en, 32'd1);
        check_val("stall_retire_count", cnt_ret, 32'd1);

        // Flush kills the captured instruction
        do_cycle(1, 6'd12, 1, 0, 3'd0, 32'hABCD, 0, 1, 32'h0);
        do_cycle(0, 6'd0, 0, 0, 3'd0, 32'h0, 0, 0, 32'h0);
        check_val("flush_wb_en",     32'(obs_wb_en),     32'd0);
        check_val("flush_retire",    32'(obs_retire),    32'd0);
        check_val("flush_fwd_valid", 32'(obs_fwd_valid), 32'd0);

        // Flush with stall: previous instruction held
        do_cycle(1, 6'd9, 1, 0, 3'd0, 32'h99, 0, 0, 32'h0);
        do_cycle(1, 6'd3, 1, 0, 3'd0, 32'h33, 1, 1, 32'h0);
        do_cycle(0, 6'd0, 0, 0, 3'd0, 32'h0, 0, 0, 32'h0);
        check_val("fs_addr",      32'(obs_addr),      32'd9);
        check_val("fs_wb_en",     32'(obs_wb_en),     32'd0);
        check_val("fs_fwd_valid", 32'(obs_fwd_valid), 32'd1);
        check_val("fs_data",      obs_fwd_data,       32'h99);

        // Asynchronous reset between edges during a held load
        do_cycle(1, 6'd7, 1, 1, 3'b010, 32'h300, 0, 0, 32'h0);
        do_cycle(0, 6'd0, 0, 0, 3'd0, 32'h0, 1, 0, 32'hCAFE_F00D);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_val("arst_wb_en",     32'(bus.wb_en),     32'd0);
        check_val("arst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        check_val("arst_retire",    32'(bus.retire),    32'd0);
        check_val("arst_data",      bus.write_data,     32'h0);
        @(negedge clk);
        do_cycle(0, 6'd0, 0, 0, 3'd0, 32'h0, 1, 0, 32'h0);
        rst = 1'b1;
        cnt_en = 0;
        for (int c = 0; c < 3; c++) begin
            do_cycle(1, 6'd4, 1, 0, 3'd0, 32'h44, 1, 0, $urandom);
            cnt_en += 32'(obs_wb_en);
        end
        check_val("post_rst_writes", cnt_en, 32'd0);

        repeat (400) rand_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
